// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultDigits = 5;

  // A nibble at or above the threshold would reach 10+ once doubled, so it is pre-corrected.
  localparam logic [3:0] AddThresh = 4'd5;
  localparam logic [3:0] AddInc    = 4'd3;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Combinational add-3 corrector for one BCD nibble ahead of the double-dabble shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= AddThresh) ? din + AddInc : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 iteration per clock, then registers
// packed digits and a leading-zero blank mask for the seven-segment display path.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned DIGITS = DefaultDigits
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + WIDTH;
  localparam logic [DIGITS-1:0] BlankReset = ~DIGITS'(1);

  state_e            state_q;
  logic [WorkW-1:0]  work_q;
  logic [CntW-1:0]   cnt_q;

  logic [BcdW-1:0]   fix_bcd;
  logic [WorkW-1:0]  work_d;
  logic [DIGITS-1:0] blank_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_fix
    bcd_add3 u_add3 (
      .din  (work_q[WIDTH + 4*i +: 4]),
      .dout (fix_bcd[4*i +: 4])
    );
  end

  // Binary MSB moves into the BCD LSB as the whole register shifts.
  assign work_d = {fix_bcd, work_q[WIDTH-1:0]} << 1;

  // Scan from the top digit down; a digit is blank while everything above it is zero too.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank_d  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (work_d[WIDTH + 4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      blank   <= BlankReset;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            work_q  <= {{BcdW{1'b0}}, bin};
            cnt_q   <= CntW'(WIDTH);
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            bcd     <= work_d[WIDTH +: BcdW];
            blank   <= blank_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values against an arithmetic
// reference, and hand-written sequences for busy-start, back-to-back and reset corners.
module tb_bin2bcd_seq;

  localparam int unsigned W = 16;
  localparam int unsigned D = 5;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   bin   = '0;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   blank;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;

  bin2bcd_seq #(
    .WIDTH  (W),
    .DIGITS (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .blank (blank),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0]   bin;
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, blank by magnitude comparison.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] ref_blank(input int unsigned v);
    logic [D-1:0] b;
    int unsigned p;
    b = '0;
    p = 10;
    for (int i = 1; i < D; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  // Start one conversion and follow it to done, checking latency, busy and result.
  task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] exp_bcd,
                         input logic [D-1:0] exp_blank, input string tag);
    int n;
    logic busy_ok;
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = $urandom_range(0, 65535);
    busy_ok = 1'b1;
    n = 999;
    for (int k = 1; k <= 40; k++) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      if (done) begin
        n = k;
        break;
      end
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_busy_held"}, {31'd0, busy_ok}, 1);
    check({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
    check({tag, "_blank"}, {27'd0, blank}, {27'd0, exp_blank});
    check({tag, "_busy_low"}, {31'd0, busy}, 0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int n;
    int dones;
    logic [W-1:0] v;

    vecs[0] = '{16'd1234,  20'h01234, 5'b10000};
    vecs[1] = '{16'hFFFF,  20'h65535, 5'b00000};
    vecs[2] = '{16'd0,     20'h00000, 5'b11110};
    vecs[3] = '{16'd7,     20'h00007, 5'b11110};
    vecs[4] = '{16'd10,    20'h00010, 5'b11100};
    vecs[5] = '{16'd500,   20'h00500, 5'b11000};
    vecs[6] = '{16'd9999,  20'h09999, 5'b10000};
    vecs[7] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[8] = '{16'd100,   20'h00100, 5'b11000};
    vecs[9] = '{16'd1,     20'h00001, 5'b11110};

    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("rst_bcd", {12'd0, bcd}, 0);
    check("rst_blank", {27'd0, blank}, 32'b11110);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);

    foreach (vecs[i]) convert(vecs[i].bin, vecs[i].bcd, vecs[i].blank, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      v = W'($urandom_range(0, 65535));
      convert(v, ref_bcd(v), ref_blank(v), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Start while busy is ignored.
    bin   = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        bin   = 16'd99;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) dones++;
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_bcd", {12'd0, bcd}, 32'h00007);
    check("busy_start_blank", {27'd0, blank}, 32'b11110);

    // Start held in the done cycle is accepted immediately.
    bin   = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 999;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        n = k;
        break;
      end
    end
    check("b2b_first_latency", n, W);
    check("b2b_first_bcd", {12'd0, bcd}, 32'h00009);
    bin   = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accept_busy", {31'd0, busy}, 1);
    n = 999;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (done) begin
        n = k;
        break;
      end
    end
    check("b2b_gap", n, W + 1);
    check("b2b_bcd", {12'd0, bcd}, 32'h00010);
    check("b2b_blank", {27'd0, blank}, 32'b11100);
    tick();

    // Reset mid-conversion aborts and restores reset outputs.
    bin   = 16'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_bcd", {12'd0, bcd}, 0);
    check("midrst_blank", {27'd0, blank}, 32'b11110);
    check("midrst_busy", {31'd0, busy}, 0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      tick();
    end
    check("midrst_no_done", dones, 0);
    convert(16'd500, 20'h00500, 5'b11000, "postrst");

    // Reset wins over a simultaneous start.
    bin   = 16'd5;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || busy) dones++;
    end
    check("rst_start_dropped", dones, 0);
    check("rst_start_bcd", {12'd0, bcd}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
